// File: rtl/bcd_pkg.sv
// Shared types and sizing helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int BIN_W_DEF   = 10;
  localparam int DIGITS_DEF  = 3;
  localparam int MAX_VAL_DEF = 999;

  // BCD field sits above the binary field in one shift register.
  function automatic int sr_width(input int bin_w, input int digits);
    return 4 * digits + bin_w;
  endfunction

  function automatic int cnt_width(input int bin_w);
    return (bin_w > 1) ? $clog2(bin_w) : 1;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle between a producer of binary counts and the BCD converter.
interface bin_to_bcd_seq_if #(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  ovf;

  modport master (
    output start, bin,
    input  busy, done, bcd, ovf
  );

  modport slave (
    input  start, bin,
    output busy, done, bcd, ovf
  );
endinterface

// File: rtl/bcd_nibble_adj.sv
// Double-dabble correction cell: a nibble of 5 or more gets +3 before the shift.
module bcd_nibble_adj (
  input  logic [3:0] nib,
  output logic [3:0] adj
);
  assign adj = (nib >= 4'd5) ? nib + 4'd3 : nib;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter; result register only changes on completion
// so the downstream display never sees intermediate shift values.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W   = BIN_W_DEF,
  parameter int DIGITS  = DIGITS_DEF,
  parameter int MAX_VAL = MAX_VAL_DEF
) (
  input  logic             clk,
  input  logic             rst,
  bin_to_bcd_seq_if.slave  bus
);

  localparam int SR_W  = sr_width(BIN_W, DIGITS);
  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = cnt_width(BIN_W);
  localparam logic [BIN_W-1:0] MAX_B = BIN_W'(MAX_VAL);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(BIN_W - 1);

  state_t             state, state_n;
  logic [SR_W-1:0]    sr, sr_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [BCD_W-1:0]   bcd_q, bcd_n;
  logic               ovf_q, ovf_n;
  logic               ovfp, ovfp_n;
  logic               done_q, done_n;

  logic [BCD_W-1:0]   bcd_f, bcd_adj;
  logic               over;

  assign bcd_f = sr[SR_W-1 -: BCD_W];
  assign over  = (bus.bin > MAX_B);

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_nibble_adj u_adj (
      .nib (bcd_f[4*g +: 4]),
      .adj (bcd_adj[4*g +: 4])
    );
  end

  always_comb begin
    state_n = state;
    sr_n    = sr;
    cnt_n   = cnt;
    bcd_n   = bcd_q;
    ovf_n   = ovf_q;
    ovfp_n  = ovfp;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          // Clamping up front keeps every nibble within 0..9 after adjustment.
          sr_n    = {{BCD_W{1'b0}}, (over ? MAX_B : bus.bin)};
          ovfp_n  = over;
          cnt_n   = '0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        sr_n  = {bcd_adj, sr[BIN_W-1:0]} << 1;
        cnt_n = cnt + 1'b1;
        if (cnt == LAST) state_n = DONE;
      end
      DONE: begin
        bcd_n   = bcd_f;
        ovf_n   = ovfp;
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sr     <= '0;
      cnt    <= '0;
      bcd_q  <= '0;
      ovf_q  <= 1'b0;
      ovfp   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      sr     <= sr_n;
      cnt    <= cnt_n;
      bcd_q  <= bcd_n;
      ovf_q  <= ovf_n;
      ovfp   <= ovfp_n;
      done_q <= done_n;
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: expected {ovf,bcd} queued at request, checked at done.
module tb_bin_to_bcd_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [12:0] sb[$];

  bin_to_bcd_seq_if #(.BIN_W(10), .DIGITS(3)) bus ();

  bin_to_bcd_seq #(.BIN_W(10), .DIGITS(3), .MAX_VAL(999)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] model(input int v);
    int c;
    c = (v > 999) ? 999 : v;
    return {(v > 999), 4'(c / 100), 4'((c / 10) % 10), 4'(c % 10)};
  endfunction

  // Drive a one-cycle start at a negedge; returns just after the accepting edge.
  task automatic pulse_start(input int v, input bit expect_result);
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = 10'(v);
    if (expect_result) sb.push_back(model(v));
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Count edges until done is seen at a negedge; busy_ok tracks busy before done.
  task automatic wait_done(output int n, output bit seen, output bit busy_ok);
    n = 0; seen = 1'b0; busy_ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (bus.done) begin seen = 1'b1; return; end
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  task automatic count_dones(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) cnt++;
    end
  endtask

  task automatic check_pop(input string name, input bit seen);
    logic [12:0] exp;
    logic [12:0] got;
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s: no done pulse within bound", name);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    exp = (sb.size() > 0) ? sb.pop_front() : 13'h1fff;
    got = {bus.ovf, bus.bcd};
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got ovf=%0b bcd=%h expected ovf=%0b bcd=%h", name, got[12], got[11:0], exp[12], exp[11:0]);
    end
  endtask

  task automatic test_reset;
    bus.start = 1'b0; bus.bin = '0; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.done, bus.ovf, bus.bcd} !== 15'd0) begin
        failures++;
        $display("FAIL reset_idle cyc%0d: busy=%0b done=%0b ovf=%0b bcd=%h expected all zero", i, bus.busy, bus.done, bus.ovf, bus.bcd);
      end
    end
  endtask

  task automatic test_basic;
    int n; bit seen, bok;
    logic [11:0] held;
    pulse_start(255, 1'b1);
    checks++;
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL basic_busy_after_accept: busy=%0b expected 1", bus.busy); end
    wait_done(n, seen, bok);
    checks++;
    if (n !== 11) begin failures++; $display("FAIL basic_latency: got %0d expected 11", n); end
    checks++;
    if (!bok) begin failures++; $display("FAIL basic_busy_window: busy dropped before done"); end
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL basic_busy_at_done: busy=%0b expected 0", bus.busy); end
    check_pop("basic_255", seen);
    held = bus.bcd;
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse: done=%0b expected 0", bus.done); end
    repeat (5) @(negedge clk);
    checks++;
    if (bus.bcd !== 12'h255 || held !== 12'h255) begin failures++; $display("FAIL basic_hold: bcd=%h expected 255", bus.bcd); end
  endtask

  task automatic test_boundaries;
    int vals[4] = '{0, 999, 1023, 7};
    int n; bit seen, bok;
    foreach (vals[i]) begin
      pulse_start(vals[i], 1'b1);
      wait_done(n, seen, bok);
      check_pop($sformatf("boundary_%0d", vals[i]), seen);
    end
  endtask

  task automatic test_busy_ignore;
    int n, d; bit seen, bok;
    pulse_start(123, 1'b1);
    repeat (2) @(posedge clk);
    pulse_start(456, 1'b0);
    wait_done(n, seen, bok);
    check_pop("busy_ignore_123", seen);
    count_dones(20, d);
    checks++;
    if (d !== 0) begin failures++; $display("FAIL busy_ignore_extra_done: got %0d expected 0", d); end
    checks++;
    if (bus.bcd !== 12'h123) begin failures++; $display("FAIL busy_ignore_hold: bcd=%h expected 123", bus.bcd); end
  endtask

  task automatic test_reset_mid;
    int n, d; bit seen, bok;
    pulse_start(888, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.ovf, bus.bcd} !== 15'd0) begin
      failures++;
      $display("FAIL reset_mid_state: busy=%0b done=%0b bcd=%h expected zeros", bus.busy, bus.done, bus.bcd);
    end
    count_dones(15, d);
    checks++;
    if (d !== 0) begin failures++; $display("FAIL reset_mid_no_done: got %0d expected 0", d); end
    pulse_start(42, 1'b1);
    wait_done(n, seen, bok);
    checks++;
    if (n !== 11) begin failures++; $display("FAIL reset_mid_latency: got %0d expected 11", n); end
    check_pop("reset_mid_42", seen);
  endtask

  task automatic test_back_to_back;
    int vals[3] = '{100, 200, 300};
    int n; bit seen, bok;
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = 10'(vals[0]);
    sb.push_back(model(vals[0]));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (i < 2) begin
        bus.bin = 10'(vals[i+1]);
        sb.push_back(model(vals[i+1]));
      end else begin
        bus.start = 1'b0;
      end
      wait_done(n, seen, bok);
      checks++;
      if (n !== 11) begin failures++; $display("FAIL b2b_spacing_%0d: got %0d expected 11", i, n); end
      check_pop($sformatf("b2b_%0d", vals[i]), seen);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.bin   = '0;
    test_reset;
    test_basic;
    test_boundaries;
    test_busy_ignore;
    test_reset_mid;
    test_back_to_back;
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_drain: %0d left expected 0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
